// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory arbiter.
// Grant encoding: one bit, master 0 or master 1.
package mem_arb_pkg;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } gnt_e;

endpackage

// File: rtl/rd_tag_fifo.sv
// In-order tag FIFO recording which master issued each outstanding read.
// Wrap-around pointers plus an explicit occupancy count; DEPTH must be a power of 2.
module rd_tag_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     push_tag,
  input  logic                     pop,
  output logic                     head_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] tags_q, tags_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      tags_d[wr_ptr_q] = push_tag;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      tags_q   <= tags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_tag = tags_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single external memory port: combinational command
// pass-through from the granted master, bounded bursts, in-order read return routing.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned BE_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned MAX_PENDING = 4,
  parameter int unsigned MAX_BURST   = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          m0_address,
  input  logic [BE_WIDTH-1:0]            m0_byteenable,
  input  logic                           m0_read,
  input  logic                           m0_write,
  input  logic [DATA_WIDTH-1:0]          m0_writedata,
  output logic                           m0_waitrequest,
  output logic [DATA_WIDTH-1:0]          m0_readdata,
  output logic                           m0_readdataready,
  input  logic [ADDR_WIDTH-1:0]          m1_address,
  input  logic [BE_WIDTH-1:0]            m1_byteenable,
  input  logic                           m1_read,
  input  logic                           m1_write,
  input  logic [DATA_WIDTH-1:0]          m1_writedata,
  output logic                           m1_waitrequest,
  output logic [DATA_WIDTH-1:0]          m1_readdata,
  output logic                           m1_readdataready,
  output logic [ADDR_WIDTH-1:0]          mem_address,
  output logic [BE_WIDTH-1:0]            mem_byteenable,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [DATA_WIDTH-1:0]          mem_writedata,
  input  logic                           mem_waitrequest,
  input  logic [DATA_WIDTH-1:0]          mem_readdata,
  input  logic                           mem_readdataready,
  output logic [$clog2(MAX_PENDING):0]   pending,
  output logic                           rd_orphan
);

  import mem_arb_pkg::*;

  localparam int unsigned PEND_W  = $clog2(MAX_PENDING) + 1;
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [PEND_W-1:0]  PEND_FULL = PEND_W'(MAX_PENDING);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  gnt_e               gnt_q, gnt_d, gnt_other;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d, burst_inc;
  logic               rd_orphan_q, rd_orphan_d;

  logic               g_read, g_write, g_rd_only, g_wait, other_req;
  logic               throttle, accept, push, pop, switch_gnt;
  logic               head_tag, fifo_empty;
  logic [PEND_W-1:0]  fifo_count;

  // Command path: granted master straight through to the memory port.
  always_comb begin
    g_read         = (gnt_q == GNT_M1) ? m1_read       : m0_read;
    g_write        = (gnt_q == GNT_M1) ? m1_write      : m0_write;
    mem_address    = (gnt_q == GNT_M1) ? m1_address    : m0_address;
    mem_byteenable = (gnt_q == GNT_M1) ? m1_byteenable : m0_byteenable;
    mem_writedata  = (gnt_q == GNT_M1) ? m1_writedata  : m0_writedata;
    other_req      = (gnt_q == GNT_M1) ? (m0_read | m0_write) : (m1_read | m1_write);
    gnt_other      = (gnt_q == GNT_M1) ? GNT_M0 : GNT_M1;

    g_rd_only = g_read & ~g_write;
    pop       = mem_readdataready & ~fifo_empty;
    // A return popping this cycle frees a slot, so a read may go out in the same cycle.
    throttle  = (fifo_count == PEND_FULL) & ~pop;

    mem_read  = ~reset & g_rd_only & ~throttle;
    mem_write = ~reset & g_write;
    g_wait    = reset | mem_waitrequest | (g_rd_only & throttle);

    m0_waitrequest = (gnt_q == GNT_M0) ? g_wait : 1'b1;
    m1_waitrequest = (gnt_q == GNT_M1) ? g_wait : 1'b1;

    accept = (mem_read | mem_write) & ~mem_waitrequest;
    push   = accept & mem_read;

    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
    m0_readdataready = ~reset & pop & (head_tag == GNT_M0);
    m1_readdataready = ~reset & pop & (head_tag == GNT_M1);
  end

  // Grant/burst next state; the burst count saturates so a long solo run still hands over on the next accept.
  always_comb begin
    gnt_d       = gnt_q;
    burst_cnt_d = burst_cnt_q;
    burst_inc   = (burst_cnt_q == BURST_MAX) ? burst_cnt_q : burst_cnt_q + 1'b1;
    switch_gnt  = other_req & (~(g_read | g_write) | (accept & (burst_inc == BURST_MAX)));
    rd_orphan_d = rd_orphan_q | (mem_readdataready & fifo_empty);
    if (switch_gnt) begin
      gnt_d       = gnt_other;
      burst_cnt_d = '0;
    end else if (accept) begin
      burst_cnt_d = burst_inc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_q       <= GNT_M0;
      burst_cnt_q <= '0;
      rd_orphan_q <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      burst_cnt_q <= burst_cnt_d;
      rd_orphan_q <= rd_orphan_d;
    end
  end

  rd_tag_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_tag_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_tag (gnt_q),
    .pop      (pop),
    .head_tag (head_tag),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign pending   = fifo_count;
  assign rd_orphan = rd_orphan_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized
// traffic checked against a queue-based model of the memory and both masters.
module tb_mem_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;
  localparam int unsigned BEW = 2;
  localparam int unsigned MAX_PENDING = 4;
  localparam int unsigned MAX_BURST = 8;

  logic clock = 1'b0;
  logic reset;
  logic [AW-1:0]  m0_address, m1_address, mem_address;
  logic [BEW-1:0] m0_byteenable, m1_byteenable, mem_byteenable;
  logic           m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0]  m0_writedata, m1_writedata, mem_writedata;
  logic           m0_waitrequest, m1_waitrequest;
  logic [DW-1:0]  m0_readdata, m1_readdata, mem_readdata;
  logic           m0_readdataready, m1_readdataready;
  logic           mem_read, mem_write, mem_waitrequest, mem_readdataready;
  logic [2:0]     pending;
  logic           rd_orphan;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  mem_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .BE_WIDTH    (BEW),
    .MAX_PENDING (MAX_PENDING),
    .MAX_BURST   (MAX_BURST)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .m0_address        (m0_address),
    .m0_byteenable     (m0_byteenable),
    .m0_read           (m0_read),
    .m0_write          (m0_write),
    .m0_writedata      (m0_writedata),
    .m0_waitrequest    (m0_waitrequest),
    .m0_readdata       (m0_readdata),
    .m0_readdataready  (m0_readdataready),
    .m1_address        (m1_address),
    .m1_byteenable     (m1_byteenable),
    .m1_read           (m1_read),
    .m1_write          (m1_write),
    .m1_writedata      (m1_writedata),
    .m1_waitrequest    (m1_waitrequest),
    .m1_readdata       (m1_readdata),
    .m1_readdataready  (m1_readdataready),
    .mem_address       (mem_address),
    .mem_byteenable    (mem_byteenable),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdataready (mem_readdataready),
    .pending           (pending),
    .rd_orphan         (rd_orphan)
  );

  // Memory contents as seen by reads: a fixed function of the address.
  function automatic logic [15:0] rdata_of(input logic [19:0] a);
    return a[15:0] ^ {a[19:16], 12'h5A3};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    m0_address = '0; m0_byteenable = 2'b11; m0_read = 0; m0_write = 0; m0_writedata = '0;
    m1_address = '0; m1_byteenable = 2'b11; m1_read = 0; m1_write = 0; m1_writedata = '0;
    mem_waitrequest = 0; mem_readdata = '0; mem_readdataready = 0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_cmd(input int m, input bit rd, input bit wr, input logic [19:0] a,
                         input logic [15:0] d);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d;
    end
  endtask

  // Hold a single command until accepted (bounded), then release it.
  task automatic issue(input int m, input bit rd, input logic [19:0] a, input logic [15:0] d);
    bit done;
    done = 0;
    set_cmd(m, rd, !rd, a, d);
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if ((m == 0) ? !m0_waitrequest : !m1_waitrequest) begin
        chk("issue_cmd", {mem_read, mem_write, mem_address}, {rd, !rd, a});
        done = 1;
      end
      tick();
    end
    chk("issue_accept", done, 1);
    set_cmd(m, 0, 0, a, d);
  endtask

  // Random-phase model state
  bit             cmd_v[2], cmd_rd[2], cmd_wr[2], acc[2];
  logic [19:0]    cmd_a[2];
  logic [15:0]    cmd_d[2];
  logic [1:0]     cmd_be[2];
  int             wait_cyc[2], starve[2];
  logic [19:0]    ret_q[$];
  bit             tag_q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached limit 1000000 before summary", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] c0, c1;
    int who, e, r;
    bit ret_now;
    logic [1:0] exp_rdr;

    // Reset values, with commands and a return beat forced onto the inputs
    reset = 1'b1;
    clear_inputs();
    m0_read = 1; m1_write = 1; mem_readdataready = 1;
    tick();
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_m0_rdr", m0_readdataready, 0);
    chk("rst_m1_rdr", m1_readdataready, 0);
    chk("rst_pending", pending, 0);
    chk("rst_orphan", rd_orphan, 0);
    reset_dut();

    // Single m0 read, data returned two cycles after accept
    m0_read = 1; m0_address = 20'h00010;
    #1;
    chk("t1_mem_read", mem_read, 1);
    chk("t1_mem_addr", mem_address, 20'h00010);
    chk("t1_m0_wait", m0_waitrequest, 0);
    chk("t1_m1_wait", m1_waitrequest, 1);
    tick();
    m0_read = 0;
    #1;
    chk("t1_pending1", pending, 1);
    tick();
    mem_readdataready = 1; mem_readdata = 16'hBEEF;
    #1;
    chk("t1_m0_rdr", m0_readdataready, 1);
    chk("t1_m0_data", m0_readdata, 16'hBEEF);
    chk("t1_m1_rdr", m1_readdataready, 0);
    tick();
    mem_readdataready = 0;
    #1;
    chk("t1_pending0", pending, 0);

    // Both masters stream writes: blocks of exactly MAX_BURST, nothing lost or duplicated
    reset_dut();
    c0 = 16'h0000; c1 = 16'h8000;
    m0_write = 1; m1_write = 1;
    m0_address = 20'(c0); m0_writedata = c0;
    m1_address = 20'(c1); m1_writedata = c1;
    for (int k = 0; k < 4 * MAX_BURST; k++) begin
      #1;
      who = (!m0_waitrequest && m1_waitrequest) ? 0 : (!m1_waitrequest && m0_waitrequest) ? 1 : 3;
      e = (k / MAX_BURST) % 2;
      chk("burst_owner", who, e);
      chk("burst_wdata", mem_writedata, (e == 1) ? c1 : c0);
      tick();
      if (who == 0) begin c0++; m0_writedata = c0; m0_address = 20'(c0); end
      if (who == 1) begin c1++; m1_writedata = c1; m1_address = 20'(c1); end
    end
    chk("burst_m0_count", c0, 16'h0010);
    chk("burst_m1_count", c1, 16'h8010);
    clear_inputs();

    // Five reads with no returns: throttle at MAX_PENDING, released by a popping return
    reset_dut();
    m0_read = 1; m0_address = 20'h00100;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("thr_accept", m0_waitrequest, 0);
      tick();
      m0_address = m0_address + 1;
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("thr_pending", pending, 4);
      chk("thr_mem_read", mem_read, 0);
      chk("thr_m0_wait", m0_waitrequest, 1);
      tick();
    end
    mem_readdataready = 1; mem_readdata = 16'h1111;
    #1;
    chk("thr_rel_mem_read", mem_read, 1);
    chk("thr_rel_m0_wait", m0_waitrequest, 0);
    chk("thr_rel_rdr", m0_readdataready, 1);
    tick();
    m0_read = 0; mem_readdataready = 0;
    #1;
    chk("thr_pending_hold", pending, 4);
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_readdataready = 1;
      #1;
      chk("thr_drain_rdr", m0_readdataready, 1);
    end
    tick();
    mem_readdataready = 0;
    #1;
    chk("thr_pending_end", pending, 0);

    // Interleaved reads route back to their issuers in order
    reset_dut();
    issue(0, 1, 20'h1, 16'h0);
    issue(1, 1, 20'h2, 16'h0);
    issue(0, 1, 20'h3, 16'h0);
    chk("il_pending", pending, 3);
    for (int k = 0; k < 3; k++) begin
      mem_readdataready = 1; mem_readdata = 16'hA1 + 16'(k);
      #1;
      chk("il_rdr", {m1_readdataready, m0_readdataready}, (k == 1) ? 2'b10 : 2'b01);
      chk("il_data", (k == 1) ? m1_readdata : m0_readdata, 16'hA1 + 16'(k));
      tick();
    end
    mem_readdataready = 0;
    #1;
    chk("il_pending0", pending, 0);

    // Orphan return beat
    reset_dut();
    mem_readdataready = 1; mem_readdata = 16'hDEAD;
    #1;
    chk("orph_rdr", {m1_readdataready, m0_readdataready}, 2'b00);
    chk("orph_before", rd_orphan, 0);
    tick();
    mem_readdataready = 0;
    #1;
    chk("orph_set", rd_orphan, 1);
    repeat (3) tick();
    chk("orph_sticky", rd_orphan, 1);
    chk("orph_pending", pending, 0);

    // Reset mid-operation with three reads pending and m1 granted
    reset_dut();
    issue(0, 1, 20'h10, 16'h0);
    issue(1, 1, 20'h20, 16'h0);
    issue(1, 1, 20'h30, 16'h0);
    chk("mr_pending3", pending, 3);
    m1_read = 1; m1_address = 20'h40; mem_readdataready = 1;
    #1;
    reset = 1'b1;
    #1;
    chk("mr_mem_read", mem_read, 0);
    chk("mr_mem_write", mem_write, 0);
    chk("mr_m0_wait", m0_waitrequest, 1);
    chk("mr_m1_wait", m1_waitrequest, 1);
    chk("mr_rdr", {m1_readdataready, m0_readdataready}, 2'b00);
    chk("mr_pending", pending, 0);
    tick();
    reset = 1'b0; mem_readdataready = 0;
    #1;
    chk("mr_gnt_m0", {m1_waitrequest, mem_read}, 2'b10);
    m1_read = 0;
    tick();
    mem_readdataready = 1;
    #1;
    chk("mr_late_rdr", {m1_readdataready, m0_readdataready}, 2'b00);
    tick();
    mem_readdataready = 0;
    #1;
    chk("mr_late_orphan", rd_orphan, 1);

    // Randomized traffic against the model
    reset_dut();
    for (int m = 0; m < 2; m++) begin
      cmd_v[m] = 0; acc[m] = 0; wait_cyc[m] = 0; starve[m] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clock);
      #1;
      for (int m = 0; m < 2; m++) begin
        if (acc[m]) cmd_v[m] = 0;
        if (!cmd_v[m] && cyc < 2600 && $urandom_range(2, 0) == 0) begin
          r = $urandom_range(3, 0);
          cmd_v[m] = 1; cmd_rd[m] = (r != 2); cmd_wr[m] = (r >= 2);
          cmd_a[m] = 20'($urandom); cmd_d[m] = 16'($urandom); cmd_be[m] = 2'($urandom);
          wait_cyc[m] = 0; starve[m] = 0;
        end
      end
      m0_read = cmd_v[0] & cmd_rd[0]; m0_write = cmd_v[0] & cmd_wr[0];
      m0_address = cmd_a[0]; m0_writedata = cmd_d[0]; m0_byteenable = cmd_be[0];
      m1_read = cmd_v[1] & cmd_rd[1]; m1_write = cmd_v[1] & cmd_wr[1];
      m1_address = cmd_a[1]; m1_writedata = cmd_d[1]; m1_byteenable = cmd_be[1];
      mem_waitrequest = ($urandom_range(3, 0) == 0);
      ret_now = (ret_q.size() > 0) && ($urandom_range(1, 0) == 1);
      mem_readdataready = ret_now;
      mem_readdata = ret_now ? rdata_of(ret_q[0]) : 16'($urandom);
      @(negedge clock);

      chk("rnd_pending", pending, ret_q.size());
      exp_rdr = ret_now ? (tag_q[0] ? 2'b10 : 2'b01) : 2'b00;
      chk("rnd_route", {m1_readdataready, m0_readdataready}, exp_rdr);
      if (ret_now)
        chk("rnd_rdata", tag_q[0] ? m1_readdata : m0_readdata, rdata_of(ret_q[0]));

      acc[0] = cmd_v[0] & !m0_waitrequest;
      acc[1] = cmd_v[1] & !m1_waitrequest;
      chk("rnd_one_accept", acc[0] & acc[1], 0);
      for (int m = 0; m < 2; m++) begin
        if (acc[m]) begin
          chk("rnd_cmd", {mem_waitrequest, mem_read, mem_write, mem_byteenable, mem_address},
              {1'b0, !cmd_wr[m], cmd_wr[m], cmd_be[m], cmd_a[m]});
          if (cmd_wr[m]) chk("rnd_wdata", mem_writedata, cmd_d[m]);
        end else if (cmd_v[m]) begin
          wait_cyc[m]++;
          chk("rnd_liveness", wait_cyc[m] < 300, 1);
          if (acc[1-m]) begin
            starve[m]++;
            chk("rnd_fairness", starve[m] <= MAX_BURST, 1);
          end
        end
      end

      if (ret_now) begin
        void'(ret_q.pop_front());
        void'(tag_q.pop_front());
      end
      for (int m = 0; m < 2; m++) begin
        if (acc[m] && !cmd_wr[m]) begin
          ret_q.push_back(cmd_a[m]);
          tag_q.push_back(m[0]);
        end
      end
      chk("rnd_pend_limit", ret_q.size() <= MAX_PENDING, 1);
    end
    #1;
    chk("rnd_orphan", rd_orphan, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
